ptp_axis_tx_classifier: RTL and testbench
=========================================

// Module: ptp_axis_tx_classifier
// PURPOSE
//  - Inline 8-bit AXI-Stream stage directly upstream of tsu_axis_tx on the MAC TX path.
//  - Forwards every frame unchanged through a 1-deep skid register.
//  - Parses Ethernet/VLAN/PTPv2 headers on the fly.
//  - Per PTP frame, emits one descriptor (messageType, sequenceId, event flag, VLAN flag) for timestamp bookkeeping.
// PARAMETERS
//  PTP_ETHERTYPE  16'h88F7  EtherType identifying a PTPv2 (L2) frame
//  VLAN_TPID      16'h8100  TPID of a single 802.1Q tag (one tag max)
//  DROP_CNT_W     16        width of saturating descriptor-drop counter
// PORTS
//  mac_axis_aclk     in   1   sole clock
//  rst               in   1   synchronous, active-high reset
//  s_axis_tdata      in   8   frame byte from MAC client
//  s_axis_tvalid     in   1   input beat valid
//  s_axis_tready     out  1   input beat accepted when tvalid&tready
//  s_axis_tlast      in   1   last byte of frame
//  m_axis_tdata      out  8   forwarded byte (to tsu_axis_tx)
//  m_axis_tvalid     out  1   forwarded beat valid
//  m_axis_tready     in   1   downstream ready
//  m_axis_tlast      out  1   forwarded last
//  ptp_info_valid    out  1   descriptor valid; held until ptp_info_ready
//  ptp_info_ready    in   1   descriptor consumed
//  ptp_msg_type      out  4   PTP header byte0[3:0]
//  ptp_seq_id        out  16  PTP sequenceId, header bytes 30..31, big-endian
//  ptp_is_event      out  1   1 when msg_type <= 4'h3 (Sync/Delay_Req/Pdelay_Req/Pdelay_Resp)
//  ptp_vlan          out  1   frame carried a VLAN_TPID tag
//  ptp_drop_cnt      out  DROP_CNT_W  descriptors lost due to occupied holding register
// BEHAVIOUR
//  Reset:
//  - All outputs 0; s_axis_tready=1 one cycle after rst deasserts.
//  - Skid and descriptor registers are emptied.
//  - Parser returns to byte 0; the next accepted beat is taken as the start of a frame, even if reset hit mid-frame.
//  Datapath:
//  - Standard skid buffer: 1-cycle latency, full throughput, no combinational path tvalid->tready.
//  - Data, tlast and beat order are never modified; frame stalls only via m_axis_tready.
//  Parser:
//  - Driven only by accepted input beats.
//  - 6-bit byte counter, saturating at 63; no wrap on jumbo frames.
//  FSM states:
//  - S_ETH: bytes 0..13; capture EtherType from bytes 12..13. At byte 13:
//    - ==VLAN_TPID -> S_VLAN
//    - ==PTP_ETHERTYPE -> S_PTP (hdr base 14)
//    - else -> S_SKIP
//  - S_VLAN: bytes 14..17, inner EtherType from 16..17. At byte 17:
//    - ==PTP_ETHERTYPE -> S_PTP (hdr base 18)
//    - else -> S_SKIP
//  - S_PTP: capture msg_type at base+0 and seq_id at base+30/31.
//    - Mark frame "complete" when base+31 is accepted, then -> S_SKIP.
//  - S_SKIP: wait for tlast.
//  - tlast in any state -> S_ETH with counter cleared.
//  Descriptor:
//  - On the accepted tlast beat of a complete PTP frame, load the holding register and raise ptp_info_valid the next cycle.
//  - Runt frames (tlast before base+31) and non-PTP frames emit nothing.
//  - If the register is still valid at load time and not being consumed in that cycle, keep the old descriptor, discard the new one, and increment ptp_drop_cnt (saturating).
//  - Simultaneous consume and load: the new descriptor replaces the old, with no drop.
//  - ptp_info_valid deasserts the cycle after a ready&valid handshake unless reloaded.
//  Fields:
//  - ptp_is_event and ptp_vlan are registered with the descriptor.
//  - Fields are stable while ptp_info_valid=1.
// STRUCTURE
//  - Shared package ptp_pkg:
//    - PTP_ETHERTYPE, VLAN_TPID
//    - header offsets (MSGTYPE_OFS=0, SEQID_OFS=30)
//    - msg-type enum (SYNC=0, DELAY_REQ=1, PDELAY_REQ=2, PDELAY_RESP=3, FOLLOW_UP=8, ...)
//    - parser state typedef
//  - One sub-module: axis_skid_buffer (WIDTH=9: tdata+tlast), reusable on the RX path.
//  - Parser FSM and descriptor register live in the top module.
// TESTING
//  1. Untagged Sync: DA 01-80-C2-00-00-0E, ET 88F7, hdr byte0=8'h00, seq bytes 44/45=8'h12/8'h34, 61B.
//     Expect: frame out bit-exact, 1-cycle latency; descriptor msg=0, seq=16'h1234, event=1, vlan=0.
//  2. Tagged Follow_Up: TPID 8100, inner 88F7, byte18=8'h08, bytes 48/49=8'hAB/8'hCD.
//     Expect: msg=8, seq=16'hABCD, event=0, vlan=1.
//  3. Non-PTP 61B frame (ET 0000), plus a 30B runt with ET 88F7.
//     Expect: both forwarded intact, no ptp_info_valid.
//  4. Back-pressure: m_axis_tready toggled randomly, s_axis_tvalid held high across 2 frames.
//     Expect: no byte lost or duplicated, tlast aligned, same descriptors as unstalled run.
//  5. ptp_info_ready=0 over 3 PTP frames (seq 1,2,3).
//     Expect: descriptor holds seq=1, ptp_drop_cnt=2. Then ready=1 pulse coinciding with frame-4 tlast: seq=4 loaded, drop_cnt stays 2.
//  6. rst asserted at byte 20 of a PTP frame, then a fresh Sync.
//     Expect: outputs 0 during reset, no stale descriptor, new frame parsed from byte 0 correctly.

Source files
------------

// File: rtl/ptp_pkg.sv
// Shared PTPv2/Ethernet constants, message types and parser types for the
// MAC-side PTP classifier and timestamping blocks.
package ptp_pkg;

   localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
   localparam logic [15:0] VLAN_TPID     = 16'h8100;

   localparam int unsigned AXIS_W       = 8;
   localparam int unsigned SKID_W       = AXIS_W + 1;
   localparam int unsigned CNT_W        = 6;
   localparam int unsigned DROP_CNT_DEF = 16;

   // Byte positions within the frame / PTP header
   localparam logic [CNT_W-1:0] ETH_TYPE_OFS  = 6'd12;
   localparam logic [CNT_W-1:0] VLAN_TYPE_OFS = 6'd16;
   localparam logic [CNT_W-1:0] ETH_HDR_LEN   = 6'd14;
   localparam logic [CNT_W-1:0] VLAN_HDR_LEN  = 6'd18;
   localparam logic [CNT_W-1:0] MSGTYPE_OFS   = 6'd0;
   localparam logic [CNT_W-1:0] SEQID_OFS     = 6'd30;

   typedef enum logic [3:0] {
      MSG_SYNC             = 4'h0,
      MSG_DELAY_REQ        = 4'h1,
      MSG_PDELAY_REQ       = 4'h2,
      MSG_PDELAY_RESP      = 4'h3,
      MSG_FOLLOW_UP        = 4'h8,
      MSG_DELAY_RESP       = 4'h9,
      MSG_PDELAY_RESP_FUP  = 4'hA,
      MSG_ANNOUNCE         = 4'hB,
      MSG_SIGNALING        = 4'hC,
      MSG_MANAGEMENT       = 4'hD
   } ptp_msg_e;

   typedef enum logic [1:0] {
      S_ETH,
      S_VLAN,
      S_PTP,
      S_SKIP
   } parser_state_e;

   typedef struct packed {
      logic [3:0]  msg_type;
      logic [15:0] seq_id;
      logic        is_event;
      logic        vlan;
   } ptp_desc_t;

   // Event messages are the ones that need an egress timestamp
   function automatic logic is_event_msg(input logic [3:0] msg_type);
      return msg_type <= 4'(MSG_PDELAY_RESP);
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Fully registered one-entry skid buffer for AXI-Stream: 1-cycle latency,
// full throughput, tready driven from a flop.
module axis_skid_buffer #(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic [WIDTH-1:0] skid_data;
   logic             skid_valid;

   // s_ready=1 implies the skid slot is empty; s_ready=0 after reset just primes it
   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (s_ready) begin
         if (!m_valid || m_ready) begin
            m_valid <= s_valid;
            if (s_valid) m_data <= s_data;
         end else if (s_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
            s_ready    <= 1'b0;
         end
      end else if (!m_valid || m_ready) begin
         m_valid <= skid_valid;
         if (skid_valid) m_data <= skid_data;
         skid_valid <= 1'b0;
         s_ready    <= 1'b1;
      end
   end

endmodule

// File: rtl/ptp_axis_tx_classifier.sv
// Inline TX AXI-Stream stage: forwards frames untouched through a skid buffer
// and emits one descriptor per complete L2 PTPv2 frame.
module ptp_axis_tx_classifier
   import ptp_pkg::*;
#(
   parameter logic [15:0] PTP_ETHERTYPE = ptp_pkg::PTP_ETHERTYPE,
   parameter logic [15:0] VLAN_TPID     = ptp_pkg::VLAN_TPID,
   parameter int unsigned DROP_CNT_W    = ptp_pkg::DROP_CNT_DEF
) (
   input  logic                  mac_axis_aclk,
   input  logic                  rst,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  ptp_info_valid,
   input  logic                  ptp_info_ready,
   output logic [3:0]            ptp_msg_type,
   output logic [15:0]           ptp_seq_id,
   output logic                  ptp_is_event,
   output logic                  ptp_vlan,
   output logic [DROP_CNT_W-1:0] ptp_drop_cnt
);

   logic [SKID_W-1:0] skid_m_data;

   axis_skid_buffer #(.WIDTH(SKID_W)) u_skid (
      .clk     (mac_axis_aclk),
      .rst     (rst),
      .s_data  ({s_axis_tlast, s_axis_tdata}),
      .s_valid (s_axis_tvalid),
      .s_ready (s_axis_tready),
      .m_data  (skid_m_data),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

   assign m_axis_tdata = skid_m_data[AXIS_W-1:0];
   assign m_axis_tlast = skid_m_data[AXIS_W];

   parser_state_e    state;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W-1:0] hdr_base;
   logic [7:0]       type_hi;
   logic [7:0]       seq_hi;
   logic [3:0]       msg_type_q;
   logic [15:0]      seq_id_q;
   logic             vlan_q;
   logic             complete_q;

   logic             beat_c;
   logic [15:0]      type_word_c;
   logic [CNT_W-1:0] hdr_ofs_c;
   logic             seq_last_c;
   logic             frame_ok_c;
   logic             load_c;
   ptp_desc_t        desc_new_c;
   ptp_desc_t        desc_q;

   assign beat_c      = s_axis_tvalid & s_axis_tready;
   assign type_word_c = {type_hi, s_axis_tdata};
   assign hdr_ofs_c   = byte_cnt - hdr_base;
   assign seq_last_c  = (state == S_PTP) && (hdr_ofs_c == SEQID_OFS + 6'd1);
   // A frame may end exactly on the last sequenceId byte
   assign frame_ok_c  = complete_q | seq_last_c;
   assign load_c      = beat_c & s_axis_tlast & frame_ok_c;

   // Header parser, advanced only by accepted input beats
   always_ff @(posedge mac_axis_aclk) begin
      if (rst) begin
         state      <= S_ETH;
         byte_cnt   <= '0;
         hdr_base   <= '0;
         type_hi    <= '0;
         seq_hi     <= '0;
         msg_type_q <= '0;
         seq_id_q   <= '0;
         vlan_q     <= 1'b0;
         complete_q <= 1'b0;
      end else if (beat_c) begin
         if (s_axis_tlast) begin
            state      <= S_ETH;
            byte_cnt   <= '0;
            vlan_q     <= 1'b0;
            complete_q <= 1'b0;
         end else begin
            if (byte_cnt != '1) byte_cnt <= byte_cnt + 6'd1;
            case (state)
               S_ETH: begin
                  if (byte_cnt == ETH_TYPE_OFS) begin
                     type_hi <= s_axis_tdata;
                  end else if (byte_cnt == ETH_TYPE_OFS + 6'd1) begin
                     if (type_word_c == VLAN_TPID) begin
                        state  <= S_VLAN;
                        vlan_q <= 1'b1;
                     end else if (type_word_c == PTP_ETHERTYPE) begin
                        state    <= S_PTP;
                        hdr_base <= ETH_HDR_LEN;
                     end else begin
                        state <= S_SKIP;
                     end
                  end
               end
               S_VLAN: begin
                  if (byte_cnt == VLAN_TYPE_OFS) begin
                     type_hi <= s_axis_tdata;
                  end else if (byte_cnt == VLAN_TYPE_OFS + 6'd1) begin
                     if (type_word_c == PTP_ETHERTYPE) begin
                        state    <= S_PTP;
                        hdr_base <= VLAN_HDR_LEN;
                     end else begin
                        state <= S_SKIP;
                     end
                  end
               end
               S_PTP: begin
                  if (hdr_ofs_c == MSGTYPE_OFS) begin
                     msg_type_q <= s_axis_tdata[3:0];
                  end else if (hdr_ofs_c == SEQID_OFS) begin
                     seq_hi <= s_axis_tdata;
                  end else if (seq_last_c) begin
                     seq_id_q   <= {seq_hi, s_axis_tdata};
                     complete_q <= 1'b1;
                     state      <= S_SKIP;
                  end
               end
               S_SKIP:  ;
               default: state <= S_ETH;
            endcase
         end
      end
   end

   always_comb begin
      desc_new_c          = '0;
      desc_new_c.msg_type = msg_type_q;
      desc_new_c.seq_id   = complete_q ? seq_id_q : {seq_hi, s_axis_tdata};
      desc_new_c.is_event = is_event_msg(msg_type_q);
      desc_new_c.vlan     = vlan_q;
   end

   // Holding register: an unconsumed descriptor wins over a new one
   always_ff @(posedge mac_axis_aclk) begin
      if (rst) begin
         ptp_info_valid <= 1'b0;
         desc_q         <= '0;
         ptp_drop_cnt   <= '0;
      end else if (load_c) begin
         if (ptp_info_valid && !ptp_info_ready) begin
            if (ptp_drop_cnt != '1) ptp_drop_cnt <= ptp_drop_cnt + DROP_CNT_W'(1);
         end else begin
            desc_q         <= desc_new_c;
            ptp_info_valid <= 1'b1;
         end
      end else if (ptp_info_valid && ptp_info_ready) begin
         ptp_info_valid <= 1'b0;
      end
   end

   assign ptp_msg_type = desc_q.msg_type;
   assign ptp_seq_id   = desc_q.seq_id;
   assign ptp_is_event = desc_q.is_event;
   assign ptp_vlan     = desc_q.vlan;

endmodule

// File: tb/tb_ptp_axis_tx_classifier.sv
// Directed bench for ptp_axis_tx_classifier: stream integrity, latency,
// descriptor contents, overflow/drop handling and mid-frame reset.
module tb_ptp_axis_tx_classifier;
   import ptp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_data;
   logic        s_valid, s_last, s_ready;
   logic [7:0]  m_data;
   logic        m_valid, m_last;
   logic        m_ready;
   logic        info_valid, info_ready;
   logic [3:0]  msg;
   logic [15:0] seq;
   logic        ev, vl;
   logic [15:0] drop;
   logic        bp_en = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] frm[$];
   logic [8:0] exp_q[$];
   logic [8:0] outq[$];
   logic [21:0] dq[$];
   int exp_rd = 0, out_rd = 0, dq_rd = 0;
   int first_in_cyc = 0, last_sof_cyc = 0, loads = 0;
   logic out_sof = 1'b1, info_prev = 1'b0;

   ptp_axis_tx_classifier dut (
      .mac_axis_aclk  (clk),
      .rst            (rst),
      .s_axis_tdata   (s_data),
      .s_axis_tvalid  (s_valid),
      .s_axis_tready  (s_ready),
      .s_axis_tlast   (s_last),
      .m_axis_tdata   (m_data),
      .m_axis_tvalid  (m_valid),
      .m_axis_tready  (m_ready),
      .m_axis_tlast   (m_last),
      .ptp_info_valid (info_valid),
      .ptp_info_ready (info_ready),
      .ptp_msg_type   (msg),
      .ptp_seq_id     (seq),
      .ptp_is_event   (ev),
      .ptp_vlan       (vl),
      .ptp_drop_cnt   (drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: records forwarded beats and consumed descriptors
   always @(negedge clk) begin
      if (rst) begin
         out_sof   = 1'b1;
         info_prev = 1'b0;
      end else begin
         if (m_valid && m_ready) begin
            outq.push_back({m_last, m_data});
            if (out_sof) last_sof_cyc = cyc;
            out_sof = m_last;
         end
         if (info_valid && info_ready) dq.push_back({msg, seq, ev, vl});
         if (info_valid && !info_prev) loads++;
         info_prev = info_valid;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
   endtask

   task automatic build(input bit vlan, input logic [15:0] et, input logic [3:0] mt,
                        input logic [15:0] sq, input int len);
      int b;
      b = vlan ? 18 : 14;
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'(i * 3 + 1));
      frm[0] = 8'h01; frm[1] = 8'h80; frm[2] = 8'hC2;
      frm[3] = 8'h00; frm[4] = 8'h00; frm[5] = 8'h0E;
      if (vlan) begin
         frm[12] = 8'h81; frm[13] = 8'h00; frm[14] = 8'h00; frm[15] = 8'h05;
         frm[16] = et[15:8]; frm[17] = et[7:0];
      end else begin
         frm[12] = et[15:8]; frm[13] = et[7:0];
      end
      if (len > b) frm[b] = {4'h0, mt};
      if (len > b + 31) begin
         frm[b + 30] = sq[15:8];
         frm[b + 31] = sq[7:0];
      end
   endtask

   task automatic send_bytes(input int first, input int last_i);
      int  k;
      bit  ok;
      for (int i = first; i <= last_i; i++) begin
         s_data  = frm[i];
         s_last  = 1'(i == frm.size() - 1);
         s_valid = 1'b1;
         ok = 1'b0;
         for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (s_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            chk("accept_timeout", 32'(ok), 32'd1);
            return;
         end
         if (i == 0) first_in_cyc = cyc;
         exp_q.push_back({s_last, s_data});
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_stream(input string tag);
      int need, k;
      need = exp_q.size() - exp_rd;
      for (k = 0; k < 3000 && (outq.size() - out_rd) < need; k++) tick(1);
      tick(5);
      chk({tag, "_beat_count"}, 32'(outq.size() - out_rd), 32'(need));
      for (int i = 0; i < need; i++)
         if (out_rd + i < outq.size())
            chk($sformatf("%s_beat%0d", tag, i), 32'(outq[out_rd + i]), 32'(exp_q[exp_rd + i]));
      out_rd = outq.size();
      exp_rd = exp_q.size();
   endtask

   task automatic wait_desc(input string tag);
      int k;
      for (k = 0; k < 100 && !info_valid; k++) tick(1);
      chk({tag, "_valid"}, 32'(info_valid), 32'd1);
   endtask

   task automatic check_desc(input string tag, input logic [3:0] emsg, input logic [15:0] eseq,
                             input logic eev, input logic evl);
      chk({tag, "_msg"},   32'(msg), 32'(emsg));
      chk({tag, "_seq"},   32'(seq), 32'(eseq));
      chk({tag, "_event"}, 32'(ev),  32'(eev));
      chk({tag, "_vlan"},  32'(vl),  32'(evl));
   endtask

   task automatic consume(input string tag);
      info_ready = 1'b1;
      tick(1);
      info_ready = 1'b0;
      chk({tag, "_released"}, 32'(info_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_m_data"},  32'(m_data),  32'd0);
      chk({tag, "_m_last"},  32'(m_last),  32'd0);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_info"},    32'(info_valid), 32'd0);
      chk({tag, "_seq"},     32'(seq),  32'd0);
      chk({tag, "_msg"},     32'(msg),  32'd0);
      chk({tag, "_drop"},    32'(drop), 32'd0);
      chk({tag, "_flags"},   32'({ev, vl}), 32'd0);
   endtask

   initial begin
      int loads_before;
      rst = 1'b1; info_ready = 1'b0;
      idle();
      tick(3);
      check_reset_outputs("por");
      @(posedge clk); #1;
      rst = 1'b0;
      tick(1);
      chk("por_s_ready", 32'(s_ready), 32'd1);

      // 1: untagged Sync
      build(1'b0, PTP_ETHERTYPE, 4'h0, 16'h1234, 61);
      send_bytes(0, 60);
      idle();
      check_stream("t1");
      chk("t1_latency", 32'(last_sof_cyc - first_in_cyc), 32'd1);
      wait_desc("t1");
      check_desc("t1", 4'h0, 16'h1234, 1'b1, 1'b0);
      consume("t1");

      // 2: VLAN-tagged Follow_Up
      build(1'b1, PTP_ETHERTYPE, 4'h8, 16'hABCD, 64);
      send_bytes(0, 63);
      idle();
      check_stream("t2");
      wait_desc("t2");
      check_desc("t2", 4'h8, 16'hABCD, 1'b0, 1'b1);
      consume("t2");

      // 3: non-PTP frame and a PTP runt produce no descriptor
      loads_before = loads;
      build(1'b0, 16'h0000, 4'h0, 16'h1111, 61);
      send_bytes(0, 60);
      idle();
      build(1'b0, PTP_ETHERTYPE, 4'h0, 16'h2222, 30);
      send_bytes(0, 29);
      idle();
      check_stream("t3");
      chk("t3_no_desc_loads", 32'(loads - loads_before), 32'd0);
      chk("t3_info_valid", 32'(info_valid), 32'd0);

      // 4: random downstream stalls, input valid held across two frames
      bp_en = 1'b1;
      info_ready = 1'b1;
      dq_rd = dq.size();
      build(1'b0, PTP_ETHERTYPE, 4'h0, 16'h1234, 61);
      send_bytes(0, 60);
      build(1'b1, PTP_ETHERTYPE, 4'h8, 16'hABCD, 64);
      send_bytes(0, 63);
      idle();
      check_stream("t4");
      bp_en = 1'b0;
      tick(3);
      chk("t4_desc_count", 32'(dq.size() - dq_rd), 32'd2);
      if (dq.size() >= dq_rd + 2) begin
         chk("t4_desc0", 32'(dq[dq_rd]),     32'({4'h0, 16'h1234, 1'b1, 1'b0}));
         chk("t4_desc1", 32'(dq[dq_rd + 1]), 32'({4'h8, 16'hABCD, 1'b0, 1'b1}));
      end
      info_ready = 1'b0;
      tick(1);

      // 5: holding register full over three frames, then reload with a coincident consume
      for (int s = 1; s <= 3; s++) begin
         build(1'b0, PTP_ETHERTYPE, 4'h0, 16'(s), 61);
         send_bytes(0, 60);
         idle();
         tick(2);
      end
      check_stream("t5a");
      chk("t5_held_valid", 32'(info_valid), 32'd1);
      chk("t5_held_seq",   32'(seq),  32'd1);
      chk("t5_drop_cnt",   32'(drop), 32'd2);
      build(1'b0, PTP_ETHERTYPE, 4'h1, 16'h0004, 61);
      send_bytes(0, 59);
      info_ready = 1'b1;
      send_bytes(60, 60);
      info_ready = 1'b0;
      idle();
      chk("t5_reload_valid", 32'(info_valid), 32'd1);
      chk("t5_reload_seq",   32'(seq),  32'd4);
      chk("t5_reload_msg",   32'(msg),  32'd1);
      chk("t5_drop_kept",    32'(drop), 32'd2);
      check_stream("t5b");

      // 6: reset at byte 20 of a PTP frame, then a fresh Sync
      build(1'b0, PTP_ETHERTYPE, 4'h0, 16'h0BAD, 61);
      send_bytes(0, 19);
      s_data = frm[20]; s_last = 1'b0; s_valid = 1'b1;
      rst = 1'b1;
      tick(1);
      idle();
      tick(1);
      check_reset_outputs("t6_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      tick(1);
      chk("t6_s_ready", 32'(s_ready), 32'd1);
      chk("t6_no_stale", 32'(info_valid), 32'd0);
      exp_rd = exp_q.size();
      out_rd = outq.size();
      build(1'b0, PTP_ETHERTYPE, 4'h0, 16'h5678, 61);
      send_bytes(0, 60);
      idle();
      check_stream("t6");
      wait_desc("t6");
      check_desc("t6", 4'h0, 16'h5678, 1'b1, 1'b0);
      chk("t6_drop", 32'(drop), 32'd0);
      consume("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
